// File: rtl/jpeg_maj_chain_serial.sv
// jpeg_maj_chain_serial: bit-serial majority/carry chain evaluator.
// Accepts one operand set (seed, a, b, tag) over in_valid/in_ready, evaluates
// one MAJ stage per clock LSB first, then presents out_res = ~(tag ^ c_STAGES)
// and out_carry[i] = c_(i+1) over out_valid/out_ready.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      operand handshake
//   in_seed, in_a, in_b    chain seed and per-stage operands
//   in_tag                 final XNOR operand
//   flush                  synchronous abort of RUN/DONE
//   out_valid/out_ready    result handshake
//   out_res, out_carry     final XNOR result and all intermediate carries
module jpeg_maj_chain_serial #(
  parameter int unsigned STAGES = 8,
  parameter int unsigned CW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_seed,
  input  logic [STAGES-1:0] in_a,
  input  logic [STAGES-1:0] in_b,
  input  logic              in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_res,
  output logic [STAGES-1:0] out_carry
);

  localparam int unsigned IW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] a_q, a_d;
  logic [STAGES-1:0] b_q, b_d;
  logic              tag_q, tag_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_res_q, out_res_d;
  logic [STAGES-1:0] out_carry_q, out_carry_d;

  // Current stage inputs and its majority result.
  logic [IW-1:0] stage_idx;
  logic          a_bit;
  logic          b_bit;
  logic          new_carry;

  always_comb begin
    stage_idx = cnt_q[IW-1:0];
    a_bit     = a_q[stage_idx];
    b_bit     = b_q[stage_idx];
    new_carry = (carry_q & a_bit) | (carry_q & b_bit) | (a_bit & b_bit);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_carry_d = out_carry_q;

    unique case (state_q)
      IDLE: begin
        // in_ready_q is low for the first cycle after reset release.
        if (in_valid && in_ready_q) begin
          a_d         = in_a;
          b_d         = in_b;
          tag_d       = in_tag;
          carry_d     = in_seed;
          cnt_d       = '0;
          out_carry_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          out_valid_d = 1'b0;
          out_res_d   = 1'b0;
          out_carry_d = '0;
          state_d     = IDLE;
        end else begin
          carry_d                = new_carry;
          out_carry_d[stage_idx] = new_carry;
          cnt_d                  = cnt_q + CW'(1);
          if (cnt_q == CW'(STAGES - 1)) begin
            out_res_d   = ~(tag_q ^ new_carry);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        // Flush wins over a simultaneous handoff.
        if (flush) begin
          out_valid_d = 1'b0;
          out_res_d   = 1'b0;
          out_carry_d = '0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Derived from next state only, never from in_valid directly.
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= 1'b0;
      out_carry_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_jpeg_maj_chain_serial.sv
// Testbench for jpeg_maj_chain_serial: directed scenarios with literal
// expectations plus a cycle-level reference model checked every cycle.
module tb_jpeg_maj_chain_serial;

  localparam int unsigned STAGES = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_seed = 1'b0;
  logic [STAGES-1:0] in_a = '0;
  logic [STAGES-1:0] in_b = '0;
  logic              in_tag = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_res;
  logic [STAGES-1:0] out_carry;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  jpeg_maj_chain_serial #(.STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_seed   (in_seed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full chain evaluated in one go from the definition.
  function automatic logic [STAGES-1:0] chain(input logic seed, input logic [STAGES-1:0] a,
                                              input logic [STAGES-1:0] b);
    logic c;
    logic [STAGES-1:0] r;
    c = seed;
    r = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = (c & a[i]) | (c & b[i]) | (a[i] & b[i]);
      r[i] = c;
    end
    return r;
  endfunction

  // Reference model: remaining-stage count plus the precomputed answer.
  logic              m_rdy = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_res = 1'b0;
  logic [STAGES-1:0] m_carry = '0;
  logic [STAGES-1:0] m_full = '0;
  logic              m_fres = 1'b0;
  int                m_left = 0;
  int                m_sets = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy = 1'b0; m_valid = 1'b0; m_res = 1'b0; m_carry = '0; m_left = 0;
    end else if (m_rdy) begin
      if (in_valid) begin
        m_full  = chain(in_seed, in_a, in_b);
        m_fres  = ~(in_tag ^ m_full[STAGES-1]);
        m_left  = STAGES;
        m_rdy   = 1'b0;
        m_carry = '0;
        m_sets++;
      end
    end else if (m_left > 0) begin
      if (flush) begin
        m_left = 0; m_rdy = 1'b1; m_carry = '0; m_res = 1'b0;
      end else begin
        m_left--;
        m_carry = '0;
        for (int i = 0; i < STAGES - m_left; i++) m_carry[i] = m_full[i];
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_res   = m_fres;
        end
      end
    end else if (m_valid) begin
      if (flush) begin
        m_valid = 1'b0; m_rdy = 1'b1; m_carry = '0; m_res = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0; m_rdy = 1'b1;
      end
    end else begin
      m_rdy = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_carry", 64'(out_carry), 64'(m_carry));
      if (m_valid) check("out_res", 64'(out_res), 64'(m_res));
    end
  end

  // Offer one set; returns at the negedge after the accepting edge.
  task automatic offer(input logic seed, input logic [STAGES-1:0] a,
                       input logic [STAGES-1:0] b, input logic tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    in_seed = seed; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    // Reset then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'h00);

    // Propagate.
    offer(1'b1, 8'h0F, 8'h00, 1'b1);
    wait_valid(lat);
    check("prop_latency", 64'(lat), 64'd8);
    check("prop_carry", 64'(out_carry), 64'h0F);
    check("prop_res", 64'(out_res), 64'd0);
    handoff();

    // All-ones with back-pressure.
    offer(1'b0, 8'hFF, 8'hFF, 1'b1);
    wait_valid(lat);
    check("ones_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      check("ones_carry", 64'(out_carry), 64'hFF);
      check("ones_res", 64'(out_res), 64'd1);
      check("ones_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    handoff();

    // Kill, then back-to-back offer held across the handoff.
    offer(1'b1, 8'h00, 8'h00, 1'b0);
    wait_valid(lat);
    check("kill_carry", 64'(out_carry), 64'h00);
    check("kill_res", 64'(out_res), 64'd1);
    in_seed = 1'b1; in_a = 8'h0F; in_b = 8'h00; in_tag = 1'b1; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_bubble_ready", 64'(in_ready), 64'd1);
    check("b2b_bubble_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("b2b_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_latency", 64'(lat), 64'd8);
    check("b2b_carry", 64'(out_carry), 64'h0F);
    handoff();

    // Flush mid-RUN at cnt=3.
    offer(1'b1, 8'hFF, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_carry", 64'(out_carry), 64'h00);
    offer(1'b0, 8'h3C, 8'hA5, 1'b0);
    wait_valid(lat);
    check("post_flush_carry", 64'(out_carry), 64'h3C);
    check("post_flush_res", 64'(out_res), 64'd1);
    handoff();

    // Async reset mid-DONE.
    offer(1'b0, 8'hFF, 8'hFF, 1'b1);
    wait_valid(lat);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_out_carry", 64'(out_carry), 64'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    m_sets = 0;
    for (int i = 0; i < 20000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_seed   = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_tag    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    check("rand_sets_seen", 64'(m_sets > 500), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
